// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the decoder and the hazard scoreboard.
// The decoder drives the issue/source fields; the scoreboard returns stall, forward selects and occupancy.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
);
  logic                          forward_EN;
  logic                          issue_valid;
  logic [REG_ADDR_W-1:0]         issue_dest;
  logic                          issue_wb_en;
  logic                          issue_mem_r;
  logic                          flush;
  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
  logic [NUM_SRC-1:0]            src_used;
  logic                          stall;
  logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
  logic [SEL_W-1:0]              pending_cnt;

  modport master (
    output forward_EN, issue_valid, issue_dest, issue_wb_en, issue_mem_r,
    output flush, src_addr, src_used,
    input  stall, fwd_sel, pending_cnt
  );

  modport slave (
    input  forward_EN, issue_valid, issue_dest, issue_wb_en, issue_mem_r,
    input  flush, src_addr, src_used,
    output stall, fwd_sel, pending_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight writers behind decode; raises a decode stall
// and selects the youngest forwarding source for every decode operand.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_scoreboard_if.slave   hz
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  logic [PIPE_DEPTH-1:0]                 valid_q, valid_d;
  logic [PIPE_DEPTH-1:0]                 load_q, load_d;
  logic [PIPE_DEPTH-1:0][REG_ADDR_W-1:0] dest_q, dest_d;
  logic [SEL_W-1:0]                      pending_cnt_q, pending_cnt_d;

  logic                     stall_s;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_s;
  logic [REG_ADDR_W-1:0]    addr_s;
  logic                     hit_s;
  logic                     young_load_s;
  logic [SEL_W-1:0]         kidx_s;

  // Per-source youngest-match search; the oldest-to-youngest scan lets the lowest slot win.
  always_comb begin
    stall_s      = 1'b0;
    fwd_sel_s    = '0;
    addr_s       = '0;
    hit_s        = 1'b0;
    young_load_s = 1'b0;
    kidx_s       = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      addr_s       = hz.src_addr[j*REG_ADDR_W +: REG_ADDR_W];
      hit_s        = 1'b0;
      young_load_s = 1'b0;
      kidx_s       = '0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && (dest_q[k] == addr_s)) begin
          hit_s        = 1'b1;
          kidx_s       = SEL_W'(k);
          young_load_s = load_q[k] && (k < LOAD_LAT);
        end else begin
          hit_s        = hit_s;
        end
      end
      hit_s = hit_s & hz.src_used[j] & (addr_s != '0);
      if (!hz.forward_EN) begin
        stall_s = stall_s | hit_s;
      end else begin
        stall_s = stall_s | (hit_s & young_load_s);
        fwd_sel_s[j*SEL_W +: SEL_W] = hit_s ? (kidx_s + SEL_W'(1)) : '0;
      end
    end
  end

  // Next slot contents: decode enters slot0 unless stalled, flushed, non-writing or targeting r0.
  always_comb begin
    valid_d       = '0;
    load_d        = '0;
    dest_d        = '0;
    pending_cnt_d = '0;
    valid_d[0] = hz.issue_valid & hz.issue_wb_en & ~stall_s & ~hz.flush &
                 (hz.issue_dest != '0);
    dest_d[0]  = hz.issue_dest;
    load_d[0]  = hz.issue_mem_r;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      dest_d[i]  = dest_q[i-1];
      load_d[i]  = load_q[i-1];
    end
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      pending_cnt_d = pending_cnt_d + SEL_W'(valid_d[i]);
    end
  end

  // Slot state and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      load_q        <= '0;
      dest_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      load_q        <= load_d;
      dest_q        <= dest_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign hz.stall       = stall_s;
  assign hz.fwd_sel     = fwd_sel_s;
  assign hz.pending_cnt = pending_cnt_q;
endmodule
